// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer.
// Provides the FSM state encoding and the counter width function.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit-counter width; a floor of 1 keeps the vector legal.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load and serial-output bundle of the PISO serializer.
// master: upstream/downstream side; slave: the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             ser_ready;
    logic             o;
    logic             o_valid;
    logic             last;
    logic             busy;

    modport master (
        output load_data, load_valid, ser_ready,
        input  load_ready, o, o_valid, last, busy
    );

    modport slave (
        input  load_data, load_valid, ser_ready,
        output load_ready, o, o_valid, last, busy
    );
endinterface

// File: rtl/piso_shreg.sv
// Loadable WIDTH-bit shift register with clear, load and shift.
// Ports: clk, clr, load, shift, d (parallel in), q (contents).
module piso_shreg #(
    parameter int WIDTH     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Shift moves bits toward the output end, zero-filling.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            if (MSB_FIRST)
                q <= {q[WIDTH-2:0], 1'b0};
            else
                q <= {1'b0, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with load and stall handshakes.
// Ports: clk, reset (sync, active-low), bus (slave side of the bundle).
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    piso_serializer_if.slave bus
);

    localparam int CW  = cnt_width(WIDTH);
    localparam int OB  = MSB_FIRST ? WIDTH - 1 : 0;
    localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic             shifting;
    logic             last_w;
    logic             accept;
    logic             adv;

    assign shifting = (state == ST_SHIFT);
    assign last_w   = shifting && (cnt == CMAX);
    assign adv      = shifting && bus.ser_ready;

    // A new word can enter while the final bit is being consumed.
    assign bus.load_ready = reset &&
        (!shifting || (last_w && bus.ser_ready));
    assign accept = bus.load_valid && bus.load_ready;

    assign bus.o       = shifting && q[OB];
    assign bus.o_valid = shifting;
    assign bus.busy    = shifting;
    assign bus.last    = last_w;

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .clr   (!reset || (adv && last_w && !accept)),
        .load  (accept),
        .shift (adv && !last_w),
        .d     (bus.load_data),
        .q     (q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bus.ser_ready) begin
                        if (last_w) begin
                            cnt   <= '0;
                            state <= accept ? ST_SHIFT : ST_IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (MSB-first and LSB-first).
// Expected bits are queued on accept and compared by a monitor.
module tb_piso_serializer;

    localparam int W = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vcnt = 0;

    // Each entry: {expected o, expected last}.
    logic [1:0] exp_q[$];

    logic [W-1:0] sipo0;
    logic [W-1:0] sipo1;

    piso_serializer_if #(.WIDTH(W)) bus0 ();
    piso_serializer_if #(.WIDTH(W)) bus1 ();

    assign bus1.load_data  = bus0.load_data;
    assign bus1.load_valid = bus0.load_valid;
    assign bus1.ser_ready  = bus0.ser_ready;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // Receiving SIPOs for the loopback checks.
    always @(posedge clk) begin
        if (!reset) begin
            sipo0 <= '0;
            sipo1 <= '0;
        end else begin
            if (bus0.o_valid) sipo0 <= {sipo0[W-2:0], bus0.o};
            if (bus1.o_valid) sipo1 <= {sipo1[W-2:0], bus1.o};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every valid cycle must match the queue head.
    always @(negedge clk) begin
        if (bus0.o_valid) begin
            vcnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit act=%0b exp=none t=%0t",
                         bus0.o, $time);
            end else begin
                chk("o", {31'd0, bus0.o}, {31'd0, exp_q[0][1]});
                chk("last", {31'd0, bus0.last}, {31'd0, exp_q[0][0]});
                chk("busy", {31'd0, bus0.busy}, 32'd1);
                if (bus0.ser_ready) void'(exp_q.pop_front());
            end
        end else begin
            chk("idle_o", {31'd0, bus0.o}, 32'd0);
        end
    end

    task automatic send_word(input logic [W-1:0] w, input bit hold);
        bit ok;
        ok = 1'b0;
        bus0.load_data  = w;
        bus0.load_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus0.load_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", {31'd0, ok}, 32'd1);
        if (ok) begin
            for (int i = 0; i < W; i++)
                exp_q.push_back({w[W-1-i], (i == W - 1)});
        end
        @(posedge clk);
        #1;
        if (!hold) bus0.load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus0.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        bus0.load_data  = 3'b101;
        bus0.load_valid = 1'b1;
        bus0.ser_ready  = 1'b1;

        // 1. reset with load_valid high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_load_ready", {31'd0, bus0.load_ready}, 32'd0);
            chk("rst_o_valid", {31'd0, bus0.o_valid}, 32'd0);
            chk("rst_busy", {31'd0, bus0.busy}, 32'd0);
            chk("rst_last", {31'd0, bus0.last}, 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_load_ready", {31'd0, bus0.load_ready}, 32'd1);
        bus0.load_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_busy", {31'd0, bus0.busy}, 32'd0);

        // 2. single word
        vcnt = 0;
        send_word(3'b101, 1'b0);
        wait_idle();
        chk("single_cycles", vcnt, 32'd3);

        // 3. back-to-back words
        @(posedge clk);
        #1 vcnt = 0;
        send_word(3'b110, 1'b1);
        send_word(3'b011, 1'b0);
        wait_idle();
        chk("b2b_cycles", vcnt, 32'd6);

        // 4. stall for two cycles after the first bit
        @(posedge clk);
        #1 vcnt = 0;
        send_word(3'b100, 1'b0);
        bus0.ser_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_load_ready", {31'd0, bus0.load_ready}, 32'd0);
        end
        @(posedge clk);
        #1 bus0.ser_ready = 1'b1;
        @(negedge clk);
        chk("stall_load_ready2", {31'd0, bus0.load_ready}, 32'd0);
        wait_idle();
        chk("stall_cycles", vcnt, 32'd5);

        // 5. reset after the second bit
        @(posedge clk);
        #1;
        send_word(3'b111, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("abort_o", {31'd0, bus0.o}, 32'd0);
        chk("abort_o_valid", {31'd0, bus0.o_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus0.busy}, 32'd0);
        chk("abort_load_ready", {31'd0, bus0.load_ready}, 32'd0);
        reset = 1'b1;
        vcnt = 0;
        send_word(3'b010, 1'b0);
        wait_idle();
        chk("post_abort_cycles", vcnt, 32'd3);

        // 6. loopback into SIPOs, both bit orders
        @(posedge clk);
        #1;
        send_word(3'b011, 1'b0);
        wait_idle();
        chk("loop_msb", {29'd0, sipo0}, 32'h3);
        chk("loop_lsb", {29'd0, sipo1}, 32'h6);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out shift register; the transmit counterpart of the team's SIPO register.
- Accepts a WIDTH-bit word over a valid/ready load handshake and emits it one bit per advancing clock, MSB first.
- A SIPO of equal width fed from o (shifting on the same clk edges as this block advances) holds the original word after WIDTH shifts.
- Supports back-to-back words with no idle gap and a downstream stall input.

Parameters:
WIDTH, 3, word width in bits; legal range ≥2.
MSB_FIRST, 1, 1 = emit load_data[WIDTH-1] first (SIPO-compatible order); 0 = emit load_data[0] first.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
load_data  input  WIDTH  word to serialize; sampled on load accept.
load_valid  input  1  upstream has a word on load_data.
load_ready  output  1  block can accept a word this cycle (combinational).
ser_ready  input  1  downstream accepts the current bit this cycle; 0 = stall.
o  output  1  serial data bit.
o_valid  output  1  o carries a valid bit.
last  output  1  current o is the final bit of the word (combinational).
busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Registers: state {IDLE, SHIFT}, shreg[WIDTH-1:0], cnt[$clog2(WIDTH)-1:0].
- Reset (reset==0 at a clk edge) forces:
  - state=IDLE, shreg=0, cnt=0.
  - o=0, o_valid=0, busy=0, last=0.
  - load_ready held 0 combinationally while reset==0; loads ignored.
- Reset mid-word aborts the word. No partial bits follow, and the word is lost.
- o = MSB_FIRST ? shreg[WIDTH-1] : shreg[0]. o is forced 0 when o_valid==0.
- o_valid = busy = (state==SHIFT).
- last = o_valid && (cnt==WIDTH-1).
- Accept = load_valid && load_ready. load_ready = reset && (state==IDLE || (last && ser_ready)).
- IDLE:
  - On accept: shreg<=load_data, cnt<=0, state<=SHIFT.
  - The first bit appears on o in the next cycle, giving a latency of 1 clk from accept.
- SHIFT, ser_ready==0: stall. shreg, cnt and o hold, and o_valid stays 1.
- SHIFT, ser_ready==1 and not last: shift shreg by one toward the output end, zero-fill; cnt<=cnt+1.
- SHIFT, ser_ready==1 and last:
  - If load_valid: reload shreg<=load_data, cnt<=0, stay in SHIFT. This is a back-to-back word, with no gap cycle.
  - Else: state<=IDLE, cnt<=0, shreg<=0.
- An unstalled word occupies exactly WIDTH cycles of o_valid=1. Stall cycles add 1:1.
- load_data changes while not accepting have no effect. load_valid deasserted without accept is legal.
- cnt never exceeds WIDTH-1. No wrap beyond that is reachable.

Decomposition:
- Shared package holds:
  - state enum constants ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - the function cnt_width(WIDTH)=$clog2(WIDTH).
- One sub-module is natural: piso_shreg, the WIDTH-bit loadable shift register with load/shift/clear controls and direction select.
- The FSM, counter and handshake logic stay in the top module.

Test Plan:
1. Reset: hold reset=0 for 2 clks with load_valid=1 -> load_ready=0, o=0, o_valid=0, busy=0; release -> load_ready=1 while in IDLE.
2. Single word (WIDTH=3), load_data=3'b101, ser_ready=1 -> accepted on one edge. Following 3 cycles: o=1,0,1 with o_valid=1 and last=0,0,1. Then busy=0 and o_valid=0.
3. Back-to-back: 3'b110 then 3'b011 with load_valid held -> second accept on last cycle of first word. o stream 1,1,0,0,1,1 with o_valid continuously 1 for 6 cycles, and last on cycles 3 and 6.
4. Stall: 3'b100, ser_ready=0 for 2 cycles after the first bit -> o=1 held for 3 cycles, then 0,0. Total o_valid=5 cycles; load_ready=0 throughout.
5. Reset mid-word: 3'b111; assert reset after the second bit -> next cycle o=0, o_valid=0, busy=0. No third bit is emitted, and the next word is transmitted cleanly.
6. Loopback: drive o into a 3-bit SIPO clocked on clk, shifting only when o_valid (equivalently ser_ready=1 throughout); load 3'b011 -> 3 clks after the first bit appears, SIPO q=3'b011. Repeat with MSB_FIRST=0 to confirm the bit-reversed result 3'b110.
